// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Build option: define MULDIV_DIV_EN to include divide support. Without it the
// DIV state is not part of the state type.
package muldiv_pkg;

  localparam int XLEN = 32;

  // Operation encoding as presented on OpE.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdOpT;

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdStateT;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd3
  } mdStateT;
`endif

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Multiply: {carry,hi,lo} shift-add with the multiplier held in lo.
// Divide (only with MULDIV_DIV_EN): restoring shift-subtract, remainder in hi,
// dividend shifting out of lo while quotient bits shift in.
module muldiv_step #(
  parameter int XLEN = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic            isDiv,
`endif
  input  logic [XLEN-1:0] accHi,
  input  logic [XLEN-1:0] accLo,
  input  logic [XLEN-1:0] opB,
  output logic [XLEN-1:0] nextHi,
  output logic [XLEN-1:0] nextLo
);

  // Conditional add of the multiplicand, keeping the carry for the right shift.
  logic [XLEN:0] addSum;
  assign addSum = {1'b0, accHi} + {1'b0, {XLEN{accLo[0]}} & opB};

`ifdef MULDIV_DIV_EN
  // Remainder shifted left with the next dividend bit; the trial difference's
  // top bit is set exactly when the divisor does not fit.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  assign shifted = {accHi, accLo[XLEN-1]};
  assign diff    = shifted - {1'b0, opB};
`endif

  // Select the multiply or divide step result.
  always_comb begin
    nextHi = addSum[XLEN:1];
    nextLo = {addSum[0], accLo[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    if (isDiv) begin
      if (!diff[XLEN]) begin
        nextHi = diff[XLEN-1:0];
        nextLo = {accLo[XLEN-2:0], 1'b1};
      end else begin
        nextHi = shifted[XLEN-1:0];
        nextLo = {accLo[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// One datapath step per cycle on operand magnitudes, then a FIX cycle applies
// signs and writes HI/LO. Build option: MULDIV_DIV_EN enables DIV/DIVU;
// otherwise a divide start is a no-op.
module muldiv_unit #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [1:0]      OpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            MthiE,
  input  logic            MtloE,
  input  logic            MfhiE,
  input  logic            MfloE,
  output logic [XLEN-1:0] HiLoE,
  output logic            Busy,
  output logic            MdStall,
  output logic            DivZero
);
  import muldiv_pkg::*;

  localparam int CNT_W = $clog2(XLEN);

  mdStateT           stateReg, stateNext;
  logic [CNT_W-1:0]  cntReg;
  logic [XLEN-1:0]   hiReg, loReg;
  logic [XLEN-1:0]   accHiReg, accLoReg, opBReg;
  logic [XLEN-1:0]   stepHi, stepLo;
  logic [XLEN-1:0]   fixHi, fixLo;
  logic              negAReg, negBReg;
  logic              signA, signB, startIter, iterating;
  logic [XLEN-1:0]   magA, magB;
  logic [2*XLEN-1:0] prodMag, prodFix;
`ifdef MULDIV_DIV_EN
  logic              isDivReg, divZeroReg;
  logic [XLEN-1:0]   srcAReg;
`endif

  // Signs only matter for the signed ops (OpE[0] = 0).
  assign signA = ~OpE[0] & SrcAE[XLEN-1];
  assign signB = ~OpE[0] & SrcBE[XLEN-1];
  assign magA  = signA ? -SrcAE : SrcAE;
  assign magB  = signB ? -SrcBE : SrcBE;

`ifdef MULDIV_DIV_EN
  assign startIter = StartE & (stateReg == IDLE);
  assign iterating = (stateReg == MUL) | (stateReg == DIV);
`else
  assign startIter = StartE & (stateReg == IDLE) & ~OpE[1];
  assign iterating = (stateReg == MUL);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  // Next-state logic and Busy.
  always_comb begin
    stateNext = stateReg;
    Busy      = 1'b0;
    case (stateReg)
      IDLE: begin
`ifdef MULDIV_DIV_EN
        if (startIter) stateNext = OpE[1] ? DIV : MUL;
`else
        if (startIter) stateNext = MUL;
`endif
      end
      MUL: begin
        Busy = 1'b1;
        if (cntReg == '1) stateNext = FIX;
      end
`ifdef MULDIV_DIV_EN
      DIV: begin
        Busy = 1'b1;
        if (cntReg == '1) stateNext = FIX;
      end
`endif
      FIX: begin
        Busy      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Step counter: cleared on start, advanced once per iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cntReg <= '0;
    else if (startIter) cntReg <= '0;
    else if (iterating) cntReg <= cntReg + 1'b1;
  end

  muldiv_step #(.XLEN(XLEN)) uStep (
`ifdef MULDIV_DIV_EN
    .isDiv  (isDivReg),
`endif
    .accHi  (accHiReg),
    .accLo  (accLoReg),
    .opB    (opBReg),
    .nextHi (stepHi),
    .nextLo (stepLo)
  );

  // Operand capture on start, accumulator update each iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accHiReg <= '0;
      accLoReg <= '0;
      opBReg   <= '0;
      negAReg  <= 1'b0;
      negBReg  <= 1'b0;
`ifdef MULDIV_DIV_EN
      isDivReg <= 1'b0;
      srcAReg  <= '0;
`endif
    end else if (startIter) begin
      accHiReg <= '0;
      accLoReg <= magA;
      opBReg   <= magB;
      negAReg  <= signA;
      negBReg  <= signB;
`ifdef MULDIV_DIV_EN
      isDivReg <= OpE[1];
      srcAReg  <= SrcAE;
`endif
    end else if (iterating) begin
      accHiReg <= stepHi;
      accLoReg <= stepLo;
    end
  end

  assign prodMag = {accHiReg, accLoReg};
  assign prodFix = (negAReg ^ negBReg) ? -prodMag : prodMag;

  // Sign fix-up of the magnitude result; divide-by-zero returns fixed values.
  always_comb begin
    fixHi = prodFix[2*XLEN-1:XLEN];
    fixLo = prodFix[XLEN-1:0];
`ifdef MULDIV_DIV_EN
    if (isDivReg) begin
      if (opBReg == '0) begin
        fixLo = '1;
        fixHi = srcAReg;
      end else begin
        fixLo = (negAReg ^ negBReg) ? -accLoReg : accLoReg;
        fixHi = negAReg ? -accHiReg : accHiReg;
      end
    end
`endif
  end

  // HI/LO: result write in FIX; moves only in IDLE and only without a start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (stateReg == FIX) begin
      hiReg <= fixHi;
      loReg <= fixLo;
    end else if ((stateReg == IDLE) && !StartE) begin
      if (MthiE) hiReg <= SrcAE;
      if (MtloE) loReg <= SrcAE;
    end
  end

`ifdef MULDIV_DIV_EN
  // Divide-by-zero flag: set by a completing zero-divisor divide, cleared by a new start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          divZeroReg <= 1'b0;
    else if (startIter) divZeroReg <= 1'b0;
    else if ((stateReg == FIX) && isDivReg && (opBReg == '0)) divZeroReg <= 1'b1;
  end
  assign DivZero = divZeroReg;
`else
  assign DivZero = 1'b0;
`endif

  assign HiLoE   = MfhiE ? hiReg : loReg;
  assign MdStall = Busy & (StartE | MfhiE | MfloE | MthiE | MtloE);

endmodule
